// File: rtl/instr_fetch_unit.sv
// Sequential instruction prefetcher: credit-limited word requests, in-order response FIFO, flush discard.
// Optional IFU_PERF_EN adds pop and starvation counters.
module instr_fetch_unit #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DEPTH      = 4,
  parameter logic [31:0] BOOT_ADDR  = 32'h0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic [31:0]           flush_pc_i,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [31:0]           instr_rdata_o,
  output logic [31:0]           instr_pc_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_wmask_o,
  output logic [31:0]           mem_wdata_o,
`ifdef IFU_PERF_EN
  output logic [31:0]           perf_fetch_cnt_o,
  output logic [31:0]           perf_stall_cnt_o,
`endif
  input  logic [31:0]           mem_rdata_i,
  input  logic                  mem_rvalid_i
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = CW + 1;

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] pc;
  } fetch_entry_t;

  fetch_entry_t          fifo_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         cnt_q, out_q, disc_q, out_nxt;
  logic [SW-1:0]         credit_sum;
  logic [31:0]           rsp_pc_q;
  logic                  req_q, req_d, push, pop;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  unused_pc_bits;

  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    logic [31:0] r;
    r = pc;
    r[ADDR_WIDTH+1:2] = pc[ADDR_WIDTH+1:2] + ADDR_WIDTH'(1);
    return r;
  endfunction

  assign unused_pc_bits = ^flush_pc_i[1:0];

  assign mem_req_o     = req_q;
  assign mem_addr_o    = addr_q;
  assign mem_we_o      = 1'b0;
  assign mem_wmask_o   = 4'b0000;
  assign mem_wdata_o   = 32'h0;
  assign instr_valid_o = (cnt_q != '0);
  assign instr_rdata_o = fifo_q[rd_ptr_q].rdata;
  assign instr_pc_o    = fifo_q[rd_ptr_q].pc;

  always_comb begin
    push       = mem_rvalid_i && (disc_q == '0) && !flush_i;
    pop        = instr_valid_o && instr_ready_i && !flush_i;
    out_nxt    = out_q + CW'(req_q) - CW'(mem_rvalid_i);
    credit_sum = SW'(cnt_q) + SW'(out_q) + SW'(req_q) - SW'(pop);
    // A flush restarts fetching immediately; only the counter range can hold it back.
    if (flush_i) req_d = (out_nxt < CW'(2 * DEPTH - 1));
    else         req_d = (credit_sum < SW'(DEPTH));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q    <= 1'b0;
      addr_q   <= BOOT_ADDR[ADDR_WIDTH+1:2];
      out_q    <= '0;
      disc_q   <= '0;
      rsp_pc_q <= {BOOT_ADDR[31:2], 2'b00};
    end else begin
      req_q <= req_d;
      out_q <= out_nxt;
      if (flush_i)    addr_q <= flush_pc_i[ADDR_WIDTH+1:2];
      else if (req_q) addr_q <= addr_q + ADDR_WIDTH'(1);
      // Everything still unanswered after a flush cycle belongs to the old stream.
      if (flush_i)                         disc_q <= out_nxt;
      else if (mem_rvalid_i && disc_q != '0) disc_q <= disc_q - CW'(1);
      // rsp_pc_q tracks the PC of the next response that will be kept.
      if (flush_i)   rsp_pc_q <= {flush_pc_i[31:2], 2'b00};
      else if (push) rsp_pc_q <= pc_inc(rsp_pc_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= '{rdata: mem_rdata_i, pc: rsp_pc_q};
  end

`ifdef IFU_PERF_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_fetch_cnt_o <= '0;
      perf_stall_cnt_o <= '0;
    end else begin
      if (pop)                            perf_fetch_cnt_o <= perf_fetch_cnt_o + 32'd1;
      if (instr_ready_i && !instr_valid_o) perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
    end
  end
`endif

  a_no_rsp_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(mem_rvalid_i && out_q == '0));
  a_disc_le_out: assert property (@(posedge clk_i) disable iff (!rst_ni)
    disc_q <= out_q);
  a_fifo_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && !pop && cnt_q == CW'(DEPTH)));
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit against a fixed-latency memory model.
// Perf counter checks compile only with IFU_PERF_EN.
module tb_instr_fetch_unit;
  localparam int AW = 12;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          flush_i = 1'b0;
  logic [31:0]   flush_pc_i = '0;
  logic          instr_valid_o;
  logic          instr_ready_i = 1'b0;
  logic [31:0]   instr_rdata_o, instr_pc_o;
  logic          mem_req_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_we_o;
  logic [3:0]    mem_wmask_o;
  logic [31:0]   mem_wdata_o;
  logic [31:0]   mem_rdata_i;
  logic          mem_rvalid_i;
`ifdef IFU_PERF_EN
  logic [31:0]   perf_fetch_cnt_o, perf_stall_cnt_o;
`endif

  int errors = 0;
  int checks = 0;
  int mem_lat = 1;
  int reqs;

  always #5 clk_i = ~clk_i;

  instr_fetch_unit #(.ADDR_WIDTH(AW), .DEPTH(4), .BOOT_ADDR(32'h0)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .flush_pc_i(flush_pc_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_rdata_o(instr_rdata_o), .instr_pc_o(instr_pc_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_wmask_o(mem_wmask_o), .mem_wdata_o(mem_wdata_o),
`ifdef IFU_PERF_EN
    .perf_fetch_cnt_o(perf_fetch_cnt_o), .perf_stall_cnt_o(perf_stall_cnt_o),
`endif
    .mem_rdata_i(mem_rdata_i), .mem_rvalid_i(mem_rvalid_i)
  );

  function automatic logic [31:0] mdata(input logic [AW-1:0] a);
    return 32'hC0DE_0000 | {20'h0, a};
  endfunction

  // Memory: response mem_lat cycles after the request cycle, in order.
  logic [7:0]    pv;
  logic [AW-1:0] pa [8];
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pv <= '0;
      for (int i = 0; i < 8; i++) pa[i] <= '0;
    end else begin
      pv    <= {pv[6:0], mem_req_o};
      pa[0] <= mem_addr_o;
      for (int i = 1; i < 8; i++) pa[i] <= pa[i-1];
    end
  end
  assign mem_rvalid_i = pv[mem_lat-1];
  assign mem_rdata_i  = mdata(pa[mem_lat-1]);

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Leaves the bench in cycle 0; the next tick lands in cycle 1 (first request).
  task automatic do_reset(input logic rdy, input int lat);
    rst_ni = 1'b0; flush_i = 1'b0; flush_pc_i = '0;
    instr_ready_i = rdy; mem_lat = lat;
    tick; tick;
    rst_ni = 1'b1;
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_req", {31'h0, mem_req_o}, 32'h0);
    check("rst_addr", {20'h0, mem_addr_o}, 32'h0);
    check("rst_valid", {31'h0, instr_valid_o}, 32'h0);
    check("rst_ties", {mem_we_o, mem_wmask_o, mem_wdata_o[26:0]}, 32'h0);

    // Streaming, 1-cycle memory, ready=1
    do_reset(1'b1, 1);
    tick; check("s_c1_req", {31'h0, mem_req_o}, 32'h1);
          check("s_c1_addr", {20'h0, mem_addr_o}, 32'h0);
    tick; check("s_c2_addr", {20'h0, mem_addr_o}, 32'h1);
          check("s_c2_valid", {31'h0, instr_valid_o}, 32'h0);
    tick; check("s_c3_valid", {31'h0, instr_valid_o}, 32'h1);
          check("s_c3_pc", instr_pc_o, 32'h0);
          check("s_c3_data", instr_rdata_o, 32'hC0DE_0000);
    tick; check("s_c4_pc", instr_pc_o, 32'h4);
          check("s_c4_data", instr_rdata_o, 32'hC0DE_0001);
    tick; check("s_c5_pc", instr_pc_o, 32'h8);
          check("s_c5_addr", {20'h0, mem_addr_o}, 32'h4);
          check("s_c5_req", {31'h0, mem_req_o}, 32'h1);

    // Backpressure: exactly DEPTH requests, head held stable
    do_reset(1'b0, 1);
    reqs = 0;
    for (int i = 1; i <= 10; i++) begin
      tick;
      reqs += int'(mem_req_o);
      if (i == 5) check("bp_c5_data", instr_rdata_o, 32'hC0DE_0000);
    end
    check("bp_reqs", reqs, 4);
    check("bp_req_idle", {31'h0, mem_req_o}, 32'h0);
    check("bp_valid", {31'h0, instr_valid_o}, 32'h1);
    check("bp_pc_hold", instr_pc_o, 32'h0);
    check("bp_data_hold", instr_rdata_o, 32'hC0DE_0000);
    instr_ready_i = 1'b1;
    tick; check("bp_c11_pc", instr_pc_o, 32'h4);
          check("bp_c11_addr", {20'h0, mem_addr_o}, 32'h4);
          check("bp_c11_req", {31'h0, mem_req_o}, 32'h1);
    tick; check("bp_c12_pc", instr_pc_o, 32'h8);
    tick; check("bp_c13_pc", instr_pc_o, 32'hC);
    tick; check("bp_c14_pc", instr_pc_o, 32'h10);

    // Flush with two requests in flight (2-cycle memory)
    do_reset(1'b1, 2);
    tick; tick;
    flush_i = 1'b1; flush_pc_i = 32'h100;
    tick; flush_i = 1'b0;
          check("fl_c3_addr", {20'h0, mem_addr_o}, 32'h40);
          check("fl_c3_req", {31'h0, mem_req_o}, 32'h1);
          check("fl_c3_valid", {31'h0, instr_valid_o}, 32'h0);
          check("fl_c3_rvalid", {31'h0, mem_rvalid_i}, 32'h1);
    tick; check("fl_c4_valid", {31'h0, instr_valid_o}, 32'h0);
          check("fl_c4_rvalid", {31'h0, mem_rvalid_i}, 32'h1);
    tick; check("fl_c5_valid", {31'h0, instr_valid_o}, 32'h0);
    tick; check("fl_c6_valid", {31'h0, instr_valid_o}, 32'h1);
          check("fl_c6_pc", instr_pc_o, 32'h100);
          check("fl_c6_data", instr_rdata_o, 32'hC0DE_0040);
    tick; check("fl_c7_pc", instr_pc_o, 32'h104);

    // Address wrap from word 0xFFE
    do_reset(1'b1, 1);
    tick; flush_i = 1'b1; flush_pc_i = 32'h3FF8;
    tick; flush_i = 1'b0;
          check("wr_c2_addr", {20'h0, mem_addr_o}, 32'hFFE);
    tick; check("wr_c3_addr", {20'h0, mem_addr_o}, 32'hFFF);
          check("wr_c3_valid", {31'h0, instr_valid_o}, 32'h0);
    tick; check("wr_c4_addr", {20'h0, mem_addr_o}, 32'h000);
          check("wr_c4_pc", instr_pc_o, 32'h3FF8);
    tick; check("wr_c5_pc", instr_pc_o, 32'h3FFC);
    tick; check("wr_c6_pc", instr_pc_o, 32'h0);
          check("wr_c6_data", instr_rdata_o, 32'hC0DE_0000);

    // Flush coinciding with rvalid, unaligned flush PC
    do_reset(1'b1, 1);
    tick; tick; tick; tick;
    check("fr_c4_rvalid", {31'h0, mem_rvalid_i}, 32'h1);
    flush_i = 1'b1; flush_pc_i = 32'h102;
    tick; flush_i = 1'b0;
          check("fr_c5_addr", {20'h0, mem_addr_o}, 32'h40);
          check("fr_c5_valid", {31'h0, instr_valid_o}, 32'h0);
    tick; check("fr_c6_valid", {31'h0, instr_valid_o}, 32'h0);
    tick; check("fr_c7_valid", {31'h0, instr_valid_o}, 32'h1);
          check("fr_c7_pc", instr_pc_o, 32'h100);
          check("fr_c7_data", instr_rdata_o, 32'hC0DE_0040);

`ifdef IFU_PERF_EN
    // 3 starved edges (E1..E3), then pops on E4..E13
    do_reset(1'b1, 1);
    for (int i = 0; i < 13; i++) tick;
    instr_ready_i = 1'b0;
    check("pf_fetch", perf_fetch_cnt_o, 32'd10);
    check("pf_stall", perf_stall_cnt_o, 32'd3);
    tick;
    check("pf_fetch_hold", perf_fetch_cnt_o, 32'd10);
    check("pf_stall_hold", perf_stall_cnt_o, 32'd3);
    rst_ni = 1'b0;
    #1;
    check("pf_rst_fetch", perf_fetch_cnt_o, 32'd0);
    check("pf_rst_stall", perf_stall_cnt_o, 32'd0);
`endif

    // Reset asserted mid-run drops everything
    do_reset(1'b1, 1);
    tick; tick; tick; tick;
    rst_ni = 1'b0;
    #1;
    check("mr_req", {31'h0, mem_req_o}, 32'h0);
    check("mr_valid", {31'h0, instr_valid_o}, 32'h0);
    check("mr_addr", {20'h0, mem_addr_o}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
